// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: interval timer register map, control words and controller FSM states.
// The state list grows when TIMER_SCHED_SNAPSHOT_EN is defined.
package timer_sched_pkg;
  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTL    = 3'd1;
  localparam logic [2:0] A_PERL   = 3'd2;
  localparam logic [2:0] A_PERH   = 3'd3;
  localparam logic [2:0] A_SNAPL  = 3'd4;
  localparam logic [2:0] A_SNAPH  = 3'd5;
  localparam int CTL_ITO      = 0;
  localparam int CTL_CONT     = 1;
  localparam int CTL_START    = 2;
  localparam int CTL_STOP_BIT = 3;
  localparam logic [15:0] CTL_START_CONT_ITO = 16'h0007;
  localparam logic [15:0] CTL_STOP           = 16'h0008;
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, STOP
`ifdef TIMER_SCHED_SNAPSHOT_EN
    , SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP
`endif
  } state_t;
endpackage

// File: rtl/timer_sched_if.sv
// timer_sched_if: Avalon-MM bus between the scheduler (master) and the interval timer (slave).
interface timer_sched_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;
  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/timer_sched_chdiv.sv
// timer_sched_chdiv: one channel divider; fires one cycle after every div-th tick.
module timer_sched_chdiv #(
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tick,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  output logic            fire
);
  logic [DIVW-1:0] cnt;
  logic [DIVW:0]   nxt;
  logic            run, wrap;
  assign run  = en && div != '0;
  assign nxt  = {1'b0, cnt} + (DIVW+1)'(1);
  // >= so a divisor lowered below the running count wraps on the next tick
  assign wrap = nxt >= {1'b0, div};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt  <= '0;
      fire <= 1'b0;
    end else begin
      fire <= tick && run && wrap;
      if (!run) cnt <= '0;
      else if (tick) cnt <= wrap ? '0 : nxt[DIVW-1:0];
    end
endmodule

// File: rtl/timer_sched.sv
// timer_sched: Avalon-MM master that programs and services the interval timer and divides its ticks
// into NCH channel events. Define TIMER_SCHED_SNAPSHOT_EN to add the counter snapshot read path.
module timer_sched import timer_sched_pkg::*; #(
  parameter int          NCH        = 4,
  parameter int          DIVW       = 16,
  parameter logic [31:0] PERIOD_RST = 32'h0001_5F8F
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [31:0]         period,
  input  logic                period_load,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH*DIVW-1:0] ch_div,
  output logic                tick,
  output logic [31:0]         tick_count,
  output logic [NCH-1:0]      ch_event,
  output logic                busy,
  timer_sched_if.master       tmr
`ifdef TIMER_SCHED_SNAPSHOT_EN
  ,
  input  logic                snap_req,
  output logic [31:0]         snap_value,
  output logic                snap_valid
`endif
);
  state_t      state, state_n;
  logic [31:0] period_reg;
  logic        pending, cs_n, wn_n;
  logic [2:0]  addr_n;
  logic [15:0] wd_n;
`ifdef TIMER_SCHED_SNAPSHOT_EN
  logic        snap_pend;
  logic [15:0] snap_lo;
`else
  logic        unused_rd;
  assign unused_rd = ^tmr.readdata;
`endif

  always_comb begin
    state_n = state;
    cs_n    = 1'b1;
    wn_n    = 1'b0;
    addr_n  = A_STATUS;
    wd_n    = '0;
    case (state)
      IDLE:     state_n = enable ? WR_PL : IDLE;
      WR_PL:    state_n = WR_PH;
      WR_PH:    state_n = WR_CTL;
      WR_CTL:   state_n = RUN;
      ACK:      state_n = pending ? WR_PL : !enable ? STOP : RUN;
      STOP:     state_n = IDLE;
`ifdef TIMER_SCHED_SNAPSHOT_EN
      RUN:      state_n = tmr.irq ? ACK : !enable ? STOP : pending ? WR_PL : snap_pend ? SNAP_W : RUN;
      SNAP_W:   state_n = SNAP_RL;
      SNAP_RL:  state_n = SNAP_RH;
      SNAP_RH:  state_n = SNAP_CAP;
      SNAP_CAP: state_n = RUN;
`else
      RUN:      state_n = tmr.irq ? ACK : !enable ? STOP : pending ? WR_PL : RUN;
`endif
      default:  state_n = IDLE;
    endcase
    // bus outputs are registered, so they are decoded from the state being entered
    case (state_n)
      WR_PL:   {addr_n, wd_n} = {A_PERL, period_reg[15:0]};
      WR_PH:   {addr_n, wd_n} = {A_PERH, period_reg[31:16]};
      WR_CTL:  {addr_n, wd_n} = {A_CTL, CTL_START_CONT_ITO};
      ACK:     addr_n = A_STATUS;
      STOP:    {addr_n, wd_n} = {A_CTL, CTL_STOP};
`ifdef TIMER_SCHED_SNAPSHOT_EN
      SNAP_W:  addr_n = A_SNAPL;
      SNAP_RL: {addr_n, wn_n} = {A_SNAPL, 1'b1};
      SNAP_RH: {addr_n, wn_n} = {A_SNAPH, 1'b1};
`endif
      default: {cs_n, wn_n} = 2'b01;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state          <= IDLE;
      period_reg     <= PERIOD_RST;
      pending        <= 1'b1;
      tick           <= 1'b0;
      tick_count     <= '0;
      busy           <= 1'b0;
      tmr.chipselect <= 1'b0;
      tmr.write_n    <= 1'b1;
      tmr.address    <= '0;
      tmr.writedata  <= '0;
    end else begin
      state          <= state_n;
      tick           <= state_n == ACK;
      tick_count     <= state_n == ACK ? tick_count + 32'd1 : tick_count;
      busy           <= state_n != IDLE && state_n != RUN;
      tmr.chipselect <= cs_n;
      tmr.write_n    <= wn_n;
      tmr.address    <= addr_n;
      tmr.writedata  <= wd_n;
      // a load that lands while a reload is in flight re-arms it so the newest period wins
      if (period_load) begin
        period_reg <= period;
        pending    <= 1'b1;
      end else if (state_n == WR_PL) pending <= 1'b0;
    end

`ifdef TIMER_SCHED_SNAPSHOT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      snap_pend  <= 1'b0;
      snap_lo    <= '0;
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_pend  <= snap_req ? 1'b1 : state_n == SNAP_W ? 1'b0 : snap_pend;
      snap_lo    <= state == SNAP_RH ? tmr.readdata : snap_lo;
      snap_value <= state == SNAP_CAP ? {tmr.readdata, snap_lo} : snap_value;
      snap_valid <= state == SNAP_CAP;
    end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_sched_chdiv #(.DIVW(DIVW)) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .tick(tick),
      .en(ch_en[i]),
      .div(ch_div[i*DIVW +: DIVW]),
      .fire(ch_event[i])
    );
  end
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: scoreboard bench for timer_sched driving a behavioural interval timer.
// Define TIMER_SCHED_SNAPSHOT_EN to also exercise the snapshot read path.
module tb_timer_sched;
  localparam int NCH = 4, DIVW = 16;
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, period_load = 1'b0;
  logic [31:0] period = '0;
  logic [NCH-1:0] ch_en = '0;
  logic [NCH*DIVW-1:0] ch_div = '0;
  logic tick, busy;
  logic [31:0] tick_count;
  logic [NCH-1:0] ch_event;
`ifdef TIMER_SCHED_SNAPSHOT_EN
  logic snap_req = 1'b0, snap_valid;
  logic [31:0] snap_value;
  int snap_cnt = 0;
`endif
  int cyc = 0, n_vec = 0, n_err = 0, start_cyc = 0, exp_ticks = 0, last_tick = 0, t0 = 0;
  int ev_cnt [NCH];
  logic [18:0] exp_q [$];
  logic [18:0] got_w, exp_w;
  logic [31:0] t_per, t_cnt;
  logic t_run;
  bit seen;

  timer_sched_if bus();

  timer_sched #(.NCH(NCH), .DIVW(DIVW), .PERIOD_RST(32'h0001_5F8F)) dut (
`ifdef TIMER_SCHED_SNAPSHOT_EN
    .snap_req(snap_req), .snap_value(snap_value), .snap_valid(snap_valid),
`endif
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period), .period_load(period_load),
    .ch_en(ch_en), .ch_div(ch_div), .tick(tick), .tick_count(tick_count), .ch_event(ch_event),
    .busy(busy), .tmr(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // timer: reloads period on START, raises irq every period+1 clocks, status write clears it
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      t_per <= '0; t_cnt <= '0; t_run <= 1'b0; bus.irq <= 1'b0; bus.readdata <= '0;
    end else begin
      bus.readdata <= bus.address == 3'd4 ? 16'h1234 : bus.address == 3'd5 ? 16'h0001 : 16'h0000;
      if (t_run) begin
        if (t_cnt == 0) begin bus.irq <= 1'b1; t_cnt <= t_per; end
        else t_cnt <= t_cnt - 1;
      end
      if (bus.chipselect && !bus.write_n)
        case (bus.address)
          3'd0: bus.irq <= 1'b0;
          3'd1: if (bus.writedata[3]) t_run <= 1'b0;
                else if (bus.writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
          3'd2: t_per[15:0] <= bus.writedata;
          3'd3: t_per[31:16] <= bus.writedata;
          default: ;
        endcase
    end

  // monitor: every bus write is popped against the scoreboard
  always @(negedge clk) begin
    if (bus.chipselect && !bus.write_n) begin
      got_w = {bus.address, bus.writedata};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL bus_write: got %0d:%04h, nothing expected", got_w[18:16], got_w[15:0]);
      end else begin
        exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          n_err++;
          $display("FAIL bus_write: got %0d:%04h expected %0d:%04h", got_w[18:16], got_w[15:0], exp_w[18:16], exp_w[15:0]);
        end
      end
      if (got_w == {3'd1, 16'h0007}) start_cyc = cyc;
    end
    for (int i = 0; i < NCH; i++) if (ch_event[i]) ev_cnt[i]++;
`ifdef TIMER_SCHED_SNAPSHOT_EN
    if (snap_valid) snap_cnt++;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = tick;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s: no tick within 400 cycles", name);
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) ev_cnt[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {11'd0, bus.chipselect, bus.write_n, bus.address, bus.writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk("rst_flags", {26'd0, tick, busy, ch_event}, 32'd0);
    chk("rst_tick_count", tick_count, 32'd0);
    reset_n = 1'b1;
    // power-up programming with the reset period
    exp_q.push_back({3'd2, 16'h5F8F});
    exp_q.push_back({3'd3, 16'h0001});
    exp_q.push_back({3'd1, 16'h0007});
    @(negedge clk);
    enable = 1'b1;
    t0 = cyc;
    repeat (2) @(negedge clk);
    chk("busy_programming", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    chk("start_latency", start_cyc - t0, 32'd3);
    chk("busy_run", {31'd0, busy}, 32'd0);
    // reload to a 100-clock period while running
    exp_q.push_back({3'd2, 16'h0063});
    exp_q.push_back({3'd3, 16'h0000});
    exp_q.push_back({3'd1, 16'h0007});
    period = 32'd99;
    period_load = 1'b1;
    @(negedge clk);
    period_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({3'd0, 16'h0000});
      wait_tick("tick_reload");
      exp_ticks++;
      if (k > 0) chk("tick_interval", cyc - last_tick, 32'd100);
      last_tick = cyc;
    end
    chk("tick_count_reload", tick_count, exp_ticks);
    // channel dividers over 12 ticks
    @(negedge clk);
    ch_div = {16'd4, 16'd3, 16'd1, 16'd0};
    ch_en = '1;
    for (int i = 0; i < NCH; i++) ev_cnt[i] = 0;
    for (int k = 0; k < 12; k++) begin
      exp_q.push_back({3'd0, 16'h0000});
      wait_tick("tick_channels");
      exp_ticks++;
    end
    repeat (2) @(negedge clk);
    chk("ch3_div4_events", ev_cnt[3], 32'd3);
    chk("ch2_div3_events", ev_cnt[2], 32'd4);
    chk("ch1_div1_events", ev_cnt[1], 32'd12);
    chk("ch0_div0_events", ev_cnt[0], 32'd0);
    chk("tick_count_channels", tick_count, exp_ticks);
`ifdef TIMER_SCHED_SNAPSHOT_EN
    exp_q.push_back({3'd4, 16'h0000});
    snap_cnt = 0;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("snap_value", snap_value, 32'h0001_1234);
    chk("snap_valid_pulses", snap_cnt, 32'd1);
`endif
    // timeout arriving as enable falls is acknowledged before the stop
    exp_q.push_back({3'd0, 16'h0000});
    exp_q.push_back({3'd1, 16'h0008});
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = bus.irq;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL irq_wait: no irq within 400 cycles");
    end
    enable = 1'b0;
    @(negedge clk);
    chk("ack_tick_at_disable", {31'd0, tick}, 32'd1);
    exp_ticks++;
    @(negedge clk);
    chk("stop_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_bus", {31'd0, bus.chipselect}, 32'd0);
    chk("tick_count_stop", tick_count, exp_ticks);
    // reset while the period high word is being written
    exp_q.push_back({3'd2, 16'h0063});
    exp_q.push_back({3'd3, 16'h0000});
    enable = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_bus", {11'd0, bus.chipselect, bus.write_n, bus.address, bus.writedata}, {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk("midrst_flags", {26'd0, tick, busy, ch_event}, 32'd0);
    chk("midrst_tick_count", tick_count, 32'd0);
    exp_q.push_back({3'd2, 16'h5F8F});
    exp_q.push_back({3'd3, 16'h0001});
    exp_q.push_back({3'd1, 16'h0007});
    start_cyc = 0;
    @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc;
    repeat (4) @(negedge clk);
    chk("restart_latency", start_cyc - t0, 32'd3);
    chk("restart_busy", {31'd0, busy}, 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/timer_sched.md
# timer_sched

Avalon-MM master controller sitting in front of the 16-bit-register interval timer slave in the metering subsystem. It programs the timer period, starts it in continuous interrupt mode, services every timeout interrupt by clearing status, and turns each timeout into a system tick. The tick is fanned out to NCH programmable channel dividers that schedule the metering tasks (sampling, energy accumulation, display refresh). Software no longer touches the timer directly.

## Interface
- NCH, 4, number of scheduled channels (1..8)
- DIVW, 16, channel divisor width
- PERIOD_RST, 32'h0001_5F8F, period programmed after reset

- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  level; high = timer running and ticks generated
- period  in  32  new timer period (counts are period+1 clocks)
- period_load  in  1  pulse; latch period and reprogram the timer
- ch_en  in  NCH  per-channel enable
- ch_div  in  NCH*DIVW  per-channel divisor, channel i at [i*DIVW +: DIVW]
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  32  serviced timeouts since reset, wraps
- ch_event  out  NCH  one-cycle pulse per channel firing
- busy  out  1  high whenever FSM not in IDLE or RUN
- tmr_address  out  3  timer word address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  write data
- tmr_readdata  in  16  registered read data, valid one cycle after address
- tmr_irq  in  1  timer interrupt, level

## Operation
- Timer map: 0 status (write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h, 4/5 snapshot.
- Timer accepts a write in the single cycle chipselect=1, write_n=0; no waitrequest.
- FSM states: IDLE, WR_PL, WR_PH, WR_CTL, RUN, ACK, STOP.
- IDLE: bus idle; enable=1 -> WR_PL.
- WR_PL writes period_reg[15:0] to 2; WR_PH writes period_reg[31:16] to 3; WR_CTL writes 16'h0007 to 1 -> RUN.
- RUN: tmr_irq=1 -> ACK; enable=0 -> STOP; pending reload (irq low) -> WR_PL.
- ACK: writes 16'h0000 to 0; tick=1; tick_count++; then pending reload -> WR_PL, enable=0 -> STOP, else RUN.
- STOP: writes 16'h0008 to 1 -> IDLE.
- period_load: period_reg <= period, pending set; cleared on entering WR_PL. period_load during WR_PL/WR_PH re-arms pending, so the latest value is always programmed.
- Priority in RUN: irq > disable > reload. irq at disable is acknowledged (tick issued) before STOP.
- period < 8 is unsupported (status clear may collide with next timeout).
- Channels: counter cnt_i increments on tick; when cnt_i+1 == ch_div_i, cnt_i <= 0 and ch_event[i] pulses. ch_en_i=0 or ch_div_i=0: cnt_i held 0, no event. ch_div_i=1: event every tick.
- ch_div change mid-count: compare uses current value; if cnt_i >= new ch_div_i, fire on next tick and restart.

## Timing
- Reset: FSM IDLE, period_reg=PERIOD_RST, pending=1, tick=0, tick_count=0, ch_event=0, cnt_i=0, busy=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0. All bus outputs registered.
- enable rise to timer START write: 3 cycles (WR_PL, WR_PH, WR_CTL at cycles 1..3).
- tmr_irq sampled in RUN -> ACK write on next cycle; tick coincides with ACK cycle; ch_event one cycle after tick.
- Bus idle (chipselect=0) in IDLE and RUN.
- Reset mid-sequence: everything returns to reset values; timer reset by the same reset_n.

## Configuration
- TIMER_SCHED_SNAPSHOT_EN defined: adds input snap_req (pulse), outputs snap_value[31:0] and snap_valid (pulse); states SNAP_W (write to 4), SNAP_RL (address 4), SNAP_RH (address 5, capture low), SNAP_CAP (capture high, snap_valid=1) entered from RUN when snap_req latched and irq low; irq has priority over a pending snap. snap_value reset 0.
- Not defined: no snapshot ports/states; timer addresses 4/5 never driven.

## Structure
- Package timer_sched_pkg: timer register addresses, control bit positions, constants CTL_START_CONT_ITO=16'h0007, CTL_STOP=16'h0008, FSM state enum.
- Sub-module timer_sched_chdiv: one channel counter/comparator (tick, en, div -> event), generated NCH times.

## Test plan
- Reset, enable=1, PERIOD_RST -> writes 2:5F8F, 3:0001, 1:0007 on cycles 1..3; tick every 90000 cycles.
- period=32'd99, period_load while RUN -> reprogram 2:0063, 3:0000, 1:0007; ticks every 100 cycles thereafter.
- ch_div={4,3,1,0}, all enabled -> over 12 ticks: ch3 (div 4) 3 events, ch2 (div 3) 4, ch1 (div 1) 12, ch0 none.
- irq asserted in same cycle enable falls -> ACK with tick, then STOP write 1:0008, IDLE, busy low.
- Reset asserted during WR_PH -> all outputs reset; on release with enable=1 full sequence restarts from WR_PL.
- SNAPSHOT_EN: snap_req with readdata model 0x1234/0x0001 -> snap_value=32'h0001_1234, snap_valid one pulse.
